// File: rtl/result_bcd_display.sv
// Captures an 8-bit result on load, converts it to BCD by double dabble and
// scans it onto a 4-digit 7-segment display. Optional: LEADING_ZERO_BLANK_EN.
module result_bcd_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dato,
    input  logic       load,
    output logic       busy,
    output logic       bcd_valid,
    output logic [6:0] sseg,
    output logic [3:0] an
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t      state, state_next;
    logic [7:0]  shift_reg;
    logic [11:0] scratch;
    logic [3:0]  count;
    logic [3:0]  hundreds, tens, units;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]  digit_idx;
    logic [1:0]  idx_next;
    logic [3:0]  nib_next;
    logic        blank_next;
    logic        wrap;

    function automatic logic [11:0] add3(input logic [11:0] s);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? s[i*4 +: 4] + 4'd3 : s[i*4 +: 4];
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] v, input logic blank);
        logic [6:0] s;
        if (blank) begin
            s = 7'b1111111;
        end else begin
            case (v)
                4'd0:    s = 7'b1000000;
                4'd1:    s = 7'b1111001;
                4'd2:    s = 7'b0100100;
                4'd3:    s = 7'b0110000;
                4'd4:    s = 7'b0011001;
                4'd5:    s = 7'b0010010;
                4'd6:    s = 7'b0000010;
                4'd7:    s = 7'b1111000;
                4'd8:    s = 7'b0000000;
                4'd9:    s = 7'b0010000;
                default: s = 7'b1111111;
            endcase
        end
        return s;
    endfunction

    // Conversion FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CONV;
            CONV:    if (count == 4'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Shift-add-3 datapath; only meaningful while converting, so no reset
    always_ff @(posedge clk) begin
        if (state == IDLE && load) begin
            shift_reg <= dato;
            scratch   <= 12'd0;
            count     <= 4'd8;
        end else if (state == CONV) begin
            {scratch, shift_reg} <= {add3(scratch), shift_reg} << 1;
            count                <= count - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hundreds  <= 4'd0;
            tens      <= 4'd0;
            units     <= 4'd0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= (state == DONE);
            if (state == DONE) begin
                {hundreds, tens, units} <= scratch;
            end
        end
    end

    // Display scan: digit selected for the slot that begins at the next wrap
    always_comb begin
        wrap       = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
        idx_next   = digit_idx + 2'd1;
        nib_next   = 4'd0;
        blank_next = 1'b0;
        case (idx_next)
            2'd0: nib_next = units;
            2'd1: begin
                nib_next = tens;
`ifdef LEADING_ZERO_BLANK_EN
                blank_next = (hundreds == 4'd0) && (tens == 4'd0);
`else
                blank_next = 1'b0;
`endif
            end
            2'd2: begin
                nib_next = hundreds;
`ifdef LEADING_ZERO_BLANK_EN
                blank_next = (hundreds == 4'd0);
`else
                blank_next = 1'b0;
`endif
            end
            default: blank_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            an          <= 4'b1110;
            sseg        <= 7'b1000000;
        end else if (wrap) begin
            refresh_cnt <= '0;
            digit_idx   <= idx_next;
            an          <= ~(4'b0001 << idx_next);
            sseg        <= seg_decode(nib_next, blank_next);
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_result_bcd_display.sv
// Randomized self-checking bench for result_bcd_display against a decimal
// arithmetic reference model of the displayed digits.
module tb_result_bcd_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dato = 8'd0;
    logic       load = 1'b0;
    logic       busy, bcd_valid;
    logic [6:0] sseg;
    logic [3:0] an;

    int total = 0;
    int bad   = 0;

    result_bcd_display #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .dato(dato), .load(load),
        .busy(busy), .bcd_valid(bcd_valid), .sseg(sseg), .an(an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input int pos, input int value);
        int d;
        bit blank;
        d = (pos == 0) ? value % 10 : (pos == 1) ? (value / 10) % 10 : value / 100;
        blank = (pos == 3);
`ifdef LEADING_ZERO_BLANK_EN
        if (pos == 2 && value < 100) blank = 1;
        if (pos == 1 && value < 10)  blank = 1;
`endif
        if (blank) return 7'b1111111;
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Watch two full scan rounds and compare the last pattern seen per digit.
    task automatic scan_check(input int value, input string tag);
        logic [6:0] last [4];
        bit seen [4];
        int pos;
        for (int p = 0; p < 4; p++) begin
            seen[p] = 0;
            last[p] = 7'h00;
        end
        for (int c = 0; c < 8 * DIV + 2; c++) begin
            @(negedge clk);
            case (an)
                4'b1110: pos = 0;
                4'b1101: pos = 1;
                4'b1011: pos = 2;
                4'b0111: pos = 3;
                default: pos = -1;
            endcase
            total++;
            if (pos < 0) begin
                bad++;
                $display("FAIL %s_an_onehot: an=%b required exactly one low bit", tag, an);
            end else begin
                seen[pos] = 1;
                last[pos] = sseg;
            end
        end
        for (int p = 0; p < 4; p++) begin
            total++;
            if (!seen[p] || last[p] !== exp_seg(p, value)) begin
                bad++;
                $display("FAIL %s_digit%0d: seen=%0d sseg=%b required %b (value %0d)",
                         tag, p, seen[p], last[p], exp_seg(p, value), value);
            end
        end
    endtask

    // Full transaction: busy for 9 samples, then a single bcd_valid pulse, then scan.
    task automatic test_conversion(input int value, input string tag);
        @(negedge clk);
        dato = 8'(value);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            total++;
            if (busy !== 1'b1 || bcd_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s_busy_c%0d: busy=%b bcd_valid=%b required 1/0", tag, i, busy, bcd_valid);
            end
            @(negedge clk);
        end
        total++;
        if (busy !== 1'b0 || bcd_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: busy=%b bcd_valid=%b required 0/1", tag, busy, bcd_valid);
        end
        @(negedge clk);
        total++;
        if (bcd_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse_end: bcd_valid=%b required 0", tag, bcd_valid);
        end
        scan_check(value, tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (an !== 4'b1110 || sseg !== 7'b1000000 || busy !== 1'b0 || bcd_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: an=%b sseg=%b busy=%b vld=%b required 1110 1000000 0 0",
                     an, sseg, busy, bcd_valid);
        end
        rst = 1'b0;
        scan_check(0, "reset_scan");
    endtask

    task automatic test_directed();
        test_conversion(255, "d255");
        test_conversion(7, "d7");
        test_conversion(0, "d0");
        test_conversion(100, "d100");
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            test_conversion(int'($urandom_range(0, 255)), "rand");
        end
    endtask

    // Second load three cycles into a conversion must be dropped.
    task automatic test_ignore_load();
        int pulses = 0;
        int first = -1;
        @(negedge clk);
        dato = 8'd100;
        load = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            load = (c == 2);
            if (c == 2) dato = 8'd42;
            if (bcd_valid === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        total++;
        if (pulses != 1 || first != 9) begin
            bad++;
            $display("FAIL ignore_load_pulses: count=%0d at=%0d required 1 at 9", pulses, first);
        end
        scan_check(100, "ignore_load");
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        test_conversion(37, "pre_rst");
        @(negedge clk);
        dato = 8'd200;
        load = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            load = 1'b0;
            rst  = (c == 3);
            if (c == 4) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_mid_busy: busy=%b required 0", busy);
                end
            end
            if (bcd_valid === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL rst_mid_pulse: count=%0d required 0", pulses);
        end
        scan_check(0, "rst_mid_scan");
        test_conversion(200, "after_rst");
    endtask

    task automatic test_rst_with_load();
        int pulses = 0;
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b1;
        dato = 8'd99;
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (busy !== 1'b0 || bcd_valid !== 1'b0) pulses++;
            @(negedge clk);
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL rst_load: %0d cycles with busy/bcd_valid high, required 0", pulses);
        end
        scan_check(0, "rst_load_scan");
    endtask

    // Load accepted during the bcd_valid cycle starts the next conversion at once.
    task automatic test_back_to_back();
        int pulse_at [$];
        @(negedge clk);
        dato = 8'd63;
        load = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (bcd_valid === 1'b1) pulse_at.push_back(c);
            if (c == 9) begin
                dato = 8'd9;
                load = 1'b1;
            end
            if (c == 10) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_busy: busy=%b required 1", busy);
                end
            end
        end
        total++;
        if (pulse_at.size() != 2 || pulse_at[0] != 9 || pulse_at[1] != 19) begin
            bad++;
            $display("FAIL b2b_pulses: count=%0d first=%0d second=%0d required 2 at 9 and 19",
                     pulse_at.size(), (pulse_at.size() > 0) ? pulse_at[0] : -1,
                     (pulse_at.size() > 1) ? pulse_at[1] : -1);
        end
        scan_check(9, "b2b_scan");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_load();
        test_reset_mid();
        test_rst_with_load();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
